// File: rtl/dram_rd.sv
// dram_rd: single-clock DRAM burst reader.
//   On go (while ready) issues ceil(size/2) word reads starting at start_addr,
//   buffers returned INPUT_WIDTH-bit words in a FIFO and streams them out as
//   DATA_OUT_WIDTH-bit halves over a valid/ready interface. Reads are
//   credit-limited (in-flight + buffered <= FIFO_DEPTH) so the FIFO never
//   overflows. An odd size drops the unused half of the final word.
// Ports:
//   dram_clk, dram_rst         clock, asynchronous active-high reset
//   go, start_addr, size       transfer request (sampled while ready)
//   ready, done                idle indicator, one-cycle completion pulse
//   data, data_valid, data_ready  user output stream
//   dram_ready, dram_rd_en, dram_rd_addr  read command channel
//   dram_rd_data, dram_rd_valid           in-order read return channel
// Build option: define DRAM_RD_HI_FIRST_EN to emit the high half of each
//   word first (odd size then emits only the high half of the final word).
module dram_rd #(
   parameter int ADDR_WIDTH     = 15,
   parameter int SIZE_WIDTH     = 17,
   parameter int INPUT_WIDTH    = 32,
   parameter int DATA_OUT_WIDTH = 16,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                      dram_clk,
   input  logic                      dram_rst,
   input  logic                      go,
   input  logic [ADDR_WIDTH-1:0]     start_addr,
   input  logic [SIZE_WIDTH-1:0]     size,
   output logic                      ready,
   output logic                      done,
   output logic [DATA_OUT_WIDTH-1:0] data,
   output logic                      data_valid,
   input  logic                      data_ready,
   input  logic                      dram_ready,
   output logic                      dram_rd_en,
   output logic [ADDR_WIDTH-1:0]     dram_rd_addr,
   input  logic [INPUT_WIDTH-1:0]    dram_rd_data,
   input  logic                      dram_rd_valid
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

`ifdef DRAM_RD_HI_FIRST_EN
   localparam logic HI_FIRST = 1'b1;
`else
   localparam logic HI_FIRST = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                  state, state_nx;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [SIZE_WIDTH-1:0]   words_left;
   logic [SIZE_WIDTH-1:0]   reads_left;
   logic [CW-1:0]           outstanding;
   logic [CW-1:0]           fifo_count;
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;
   logic                    half_sel;   // 0: first half of head word pending
   logic [INPUT_WIDTH-1:0]  mem [FIFO_DEPTH];
   logic [INPUT_WIDTH-1:0]  head;
   logic                    issue, push, pop, accept, last_word;

   always_comb begin
      issue      = (state == S_RUN) && dram_ready && (reads_left != '0) &&
                   (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
      push       = (state == S_RUN) && dram_rd_valid;
      data_valid = (state == S_RUN) && (fifo_count != '0);
      accept     = data_valid && data_ready;
      last_word  = (words_left == SIZE_WIDTH'(1));
      // Pop after the second half, or early on the final half-word of an odd size.
      pop        = accept && (half_sel || last_word);
      head       = mem[rd_ptr];
      data       = '0;
      if (data_valid) begin
         if (half_sel ^ HI_FIRST)
            data = head[INPUT_WIDTH-1:DATA_OUT_WIDTH];
         else
            data = head[DATA_OUT_WIDTH-1:0];
      end
      dram_rd_en   = issue;
      dram_rd_addr = addr;
   end

   always_comb begin
      state_nx = state;
      ready    = 1'b0;
      done     = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (go)
               state_nx = (size == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (accept && last_word)
               state_nx = S_DONE;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge dram_clk or posedge dram_rst) begin
      if (dram_rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge dram_clk or posedge dram_rst) begin
      if (dram_rst) begin
         addr        <= '0;
         words_left  <= '0;
         reads_left  <= '0;
         outstanding <= '0;
         fifo_count  <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         half_sel    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (go && (size != '0)) begin
                  addr        <= start_addr;
                  words_left  <= size;
                  reads_left  <= (size >> 1) + SIZE_WIDTH'(size[0]);
                  outstanding <= '0;
                  fifo_count  <= '0;
                  wr_ptr      <= '0;
                  rd_ptr      <= '0;
                  half_sel    <= 1'b0;
               end
            end
            S_RUN: begin
               if (issue) begin
                  addr       <= addr + ADDR_WIDTH'(1);
                  reads_left <= reads_left - SIZE_WIDTH'(1);
               end
               case ({issue, push})
                  2'b10:   outstanding <= outstanding + CW'(1);
                  2'b01:   outstanding <= outstanding - CW'(1);
                  default: outstanding <= outstanding;
               endcase
               if (push)
                  wr_ptr <= wr_ptr + PW'(1);
               if (pop)
                  rd_ptr <= rd_ptr + PW'(1);
               case ({push, pop})
                  2'b10:   fifo_count <= fifo_count + CW'(1);
                  2'b01:   fifo_count <= fifo_count - CW'(1);
                  default: fifo_count <= fifo_count;
               endcase
               if (accept) begin
                  words_left <= words_left - SIZE_WIDTH'(1);
                  half_sel   <= !pop;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge dram_clk) begin
      if (push)
         mem[wr_ptr] <= dram_rd_data;
   end

endmodule

// File: tb/tb_dram_rd.sv
// tb_dram_rd: self-checking bench for dram_rd (default build, low half first).
//   A behavioural DRAM model returns words from a local memory image with a
//   configurable latency; read addresses and stream words are checked against
//   expectation queues filled when each transfer is started.
module tb_dram_rd;

   logic        dram_clk = 1'b0;
   logic        dram_rst;
   logic        go;
   logic [14:0] start_addr;
   logic [16:0] size;
   logic        ready, done;
   logic [15:0] data;
   logic        data_valid;
   logic        data_ready;
   logic        dram_ready;
   logic        dram_rd_en;
   logic [14:0] dram_rd_addr;
   logic [31:0] dram_rd_data;
   logic        dram_rd_valid;

   dram_rd #(
      .ADDR_WIDTH(15), .SIZE_WIDTH(17), .INPUT_WIDTH(32),
      .DATA_OUT_WIDTH(16), .FIFO_DEPTH(8)
   ) dut (
      .dram_clk(dram_clk), .dram_rst(dram_rst), .go(go),
      .start_addr(start_addr), .size(size), .ready(ready), .done(done),
      .data(data), .data_valid(data_valid), .data_ready(data_ready),
      .dram_ready(dram_ready), .dram_rd_en(dram_rd_en),
      .dram_rd_addr(dram_rd_addr), .dram_rd_data(dram_rd_data),
      .dram_rd_valid(dram_rd_valid)
   );

   always #5 dram_clk = ~dram_clk;

   typedef struct {
      logic [14:0] start;
      int unsigned size;
      int unsigned lat;
      bit          rnd_dready;
      bit          rnd_dram;
      int unsigned exp_reads;
      logic [14:0] exp_end_addr;
   } vec_t;

   typedef struct {
      logic [14:0] addr;
      int          due;
   } pend_t;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          lat = 1;
   int          reads = 0;
   int          done_cnt = 0;
   int          first_issue_cyc = -1;
   int          first_valid_cyc = -1;
   int          first_resp_cyc = -1;
   int          go_cyc = 0;
   bit          inject = 1'b0;
   logic [31:0] inject_data = '0;
   bit          prev_stall = 1'b0;
   logic [15:0] prev_data = '0;

   logic [31:0] mem [32768];
   logic [15:0] sb[$];
   logic [14:0] exp_addr_q[$];
   pend_t       pending[$];
   vec_t        vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // DRAM model: in-order responses after lat cycles, plus one-shot stray injection.
   always @(posedge dram_clk) begin
      cyc++;
      #1;
      if (inject) begin
         dram_rd_valid = 1'b1;
         dram_rd_data  = inject_data;
         inject        = 1'b0;
      end else if (pending.size() > 0 && pending[0].due <= cyc) begin
         pend_t p;
         p = pending.pop_front();
         dram_rd_valid = 1'b1;
         dram_rd_data  = mem[p.addr];
         if (first_resp_cyc < 0) first_resp_cyc = cyc;
      end else begin
         dram_rd_valid = 1'b0;
         dram_rd_data  = '0;
      end
   end

   // Monitor: outputs sampled on the falling edge.
   always @(negedge dram_clk) begin
      if (dram_rst) begin
         prev_stall = 1'b0;
      end else begin
         if (dram_rd_en) begin
            reads++;
            if (first_issue_cyc < 0) first_issue_cyc = cyc;
            if (!dram_ready) fail_now("rd_en_without_dram_ready");
            if (exp_addr_q.size() == 0) fail_now("rd_addr_unexpected_read");
            else check("rd_addr", 32'(dram_rd_addr), 32'(exp_addr_q.pop_front()));
            pending.push_back('{addr: dram_rd_addr, due: cyc + lat});
         end
         if (data_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (prev_stall) check("data_hold", {15'd0, data_valid, data}, {16'd1, prev_data});
         prev_stall = data_valid && !data_ready;
         prev_data  = data;
         if (data_valid && data_ready) begin
            if (sb.size() == 0) fail_now("stream_extra_word");
            else check("stream_data", 32'(data), 32'(sb.pop_front()));
         end
         if (done) done_cnt++;
      end
   end

   task automatic tick(input bit dr, input bit dm);
      @(posedge dram_clk);
      #1;
      data_ready = dr;
      dram_ready = dm;
   endtask

   task automatic start_txn(input logic [14:0] sa, input int unsigned sz);
      int unsigned nreads;
      logic [31:0] w;
      logic [14:0] a;
      for (int i = 0; i < 50 && !ready; i++) tick(data_ready, dram_ready);
      if (!ready) fail_now("ready_wait_timeout");
      reads = 0; done_cnt = 0;
      first_issue_cyc = -1; first_valid_cyc = -1; first_resp_cyc = -1;
      nreads = (sz + 1) / 2;
      for (int unsigned j = 0; j < nreads; j++) begin
         a = sa + 15'(j);
         exp_addr_q.push_back(a);
      end
      for (int unsigned i = 0; i < sz; i++) begin
         a = sa + 15'(i / 2);
         w = mem[a];
         sb.push_back((i % 2) ? w[31:16] : w[15:0]);
      end
      go = 1'b1; start_addr = sa; size = 17'(sz);
      go_cyc = cyc;
      @(posedge dram_clk);
      #1;
      go = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit rdr, input bit rdm);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick(rdr ? 1'($urandom_range(0, 1)) : 1'b1, rdm ? 1'($urandom_range(0, 1)) : 1'b1);
         n++;
      end
      if (done_cnt == 0) fail_now("done_timeout");
      tick(1'b1, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 32768; i++)
         mem[i] = {16'(i) ^ 16'hA5A5, 16'(i * 3 + 7)};
      mem[15'h0010] = 32'h2222_1111;
      mem[15'h0011] = 32'h4444_3333;
      mem[15'h0020] = 32'hBBBB_AAAA;
      mem[15'h0021] = 32'hDDDD_CCCC;
      mem[15'h7FFF] = 32'h9999_8888;
      mem[15'h0000] = 32'h7777_6666;

      vecs[0] = '{15'h0010,  4, 1, 1'b0, 1'b0,  2, 15'h0012};
      vecs[1] = '{15'h0020,  3, 1, 1'b0, 1'b0,  2, 15'h0022};
      vecs[2] = '{15'h7FFF,  4, 1, 1'b0, 1'b0,  2, 15'h0001};
      vecs[3] = '{15'h0100, 17, 3, 1'b1, 1'b0,  9, 15'h0109};
      vecs[4] = '{15'h0200,  1, 2, 1'b0, 1'b0,  1, 15'h0201};
      vecs[5] = '{15'h0300, 30, 2, 1'b1, 1'b1, 15, 15'h030F};

      dram_rst = 1'b1; go = 1'b0; start_addr = '0; size = '0;
      data_ready = 1'b1; dram_ready = 1'b1;
      dram_rd_data = '0; dram_rd_valid = 1'b0;
      repeat (3) @(posedge dram_clk);
      #1;
      check("reset_outputs", {26'd0, ready, done, data_valid, dram_rd_en, 2'b00},
            {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
      check("reset_data_addr", {data, 1'b0, dram_rd_addr}, 32'd0);
      dram_rst = 1'b0;
      tick(1'b1, 1'b1);

      for (int v = 0; v < 6; v++) begin
         lat = vecs[v].lat;
         start_txn(vecs[v].start, vecs[v].size);
         wait_done(2000, vecs[v].rnd_dready, vecs[v].rnd_dram);
         check($sformatf("v%0d_done_count", v), 32'(done_cnt), 32'd1);
         check($sformatf("v%0d_read_count", v), 32'(reads), 32'(vecs[v].exp_reads));
         check($sformatf("v%0d_stream_left", v), 32'(sb.size()), 32'd0);
         check($sformatf("v%0d_end_addr", v), 32'(dram_rd_addr), 32'(vecs[v].exp_end_addr));
         check($sformatf("v%0d_idle", v), {30'd0, ready, data_valid}, 32'd2);
         if (!vecs[v].rnd_dram)
            check($sformatf("v%0d_issue_latency", v), 32'(first_issue_cyc), 32'(go_cyc + 1));
         check($sformatf("v%0d_valid_latency", v), 32'(first_valid_cyc), 32'(first_resp_cyc + 1));
      end

      // Backpressure with a go during RUN
      lat = 1;
      data_ready = 1'b0;
      start_txn(15'h0400, 64);
      for (int i = 0; i < 30; i++) tick(1'b0, 1'b1);
      check("bp_reads_stalled", 32'(reads), 32'd8);
      check("bp_stall_state", {29'd0, data_valid, dram_rd_en, ready}, 32'd4);
      go = 1'b1; start_addr = 15'h1234; size = 17'd5;
      tick(1'b0, 1'b1);
      go = 1'b0;
      tick(1'b0, 1'b1);
      check("bp_go_ignored_addr", 32'(dram_rd_addr), 32'h0408);
      check("bp_go_ignored_reads", 32'(reads), 32'd8);
      wait_done(3000, 1'b0, 1'b0);
      check("bp_total_reads", 32'(reads), 32'd32);
      check("bp_stream_left", 32'(sb.size()), 32'd0);
      check("bp_done_count", 32'(done_cnt), 32'd1);
      check("bp_end_addr", 32'(dram_rd_addr), 32'h0420);

      // Zero size, then stray return while idle
      start_txn(15'h0600, 0);
      check("zero_done_pulse", {30'd0, done, ready}, 32'd2);
      tick(1'b1, 1'b1);
      check("zero_back_idle", {30'd0, done, ready}, 32'd1);
      check("zero_no_reads", 32'(reads), 32'd0);
      check("zero_done_count", 32'(done_cnt), 32'd1);
      inject_data = 32'hDEAD_BEEF; inject = 1'b1;
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      check("stray_idle_no_valid", {30'd0, data_valid, ready}, 32'd1);

      // Mid-run reset after two of four reads
      lat = 6;
      data_ready = 1'b0;
      start_txn(15'h0500, 8);
      for (int i = 0; i < 20 && reads < 2; i++) tick(1'b0, 1'b1);
      check("mr_reads_before_reset", 32'(reads), 32'd2);
      dram_rst = 1'b1;
      #1;
      check("mr_reset_outputs", {26'd0, ready, done, data_valid, dram_rd_en, 2'b00},
            {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
      check("mr_reset_data_addr", {data, 1'b0, dram_rd_addr}, 32'd0);
      pending.delete();
      sb.delete();
      exp_addr_q.delete();
      tick(1'b1, 1'b1);
      dram_rst = 1'b0;
      inject_data = 32'h1234_5678; inject = 1'b1;
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      check("mr_stray_no_valid", {30'd0, data_valid, ready}, 32'd1);
      check("mr_no_done", 32'(done_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
